// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the fetch stage: word size, the canonical NOP,
// the fetch FSM state encoding and PC helpers.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    // Instructions are word aligned; the low two address bits are forced to zero.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register. Loads on enable, loads a bubble on flush (flush
// wins over enable), otherwise holds. An enabled load with d_valid low also
// stores a bubble so a stale instruction is never presented twice.
module if_id_reg
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic            flush,
    input  logic            d_valid,
    input  logic [XLEN-1:0] d_pc,
    input  logic [XLEN-1:0] d_instr,
    output logic            q_valid,
    output logic [XLEN-1:0] q_pc,
    output logic [XLEN-1:0] q_instr
);

    logic            vld_p1;
    logic [XLEN-1:0] pc_p1;
    logic [XLEN-1:0] instr_p1;

    // IF -> ID stage boundary: bubble on reset/flush, load on enable, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            pc_p1    <= '0;
            instr_p1 <= NOP_INSTR;
        end else if (flush) begin
            vld_p1   <= 1'b0;
            pc_p1    <= '0;
            instr_p1 <= NOP_INSTR;
        end else if (enable) begin
            vld_p1   <= d_valid;
            pc_p1    <= d_valid ? d_pc : '0;
            instr_p1 <= d_valid ? d_instr : NOP_INSTR;
        end
    end

    assign q_valid = vld_p1;
    assign q_pc    = pc_p1;
    assign q_instr = instr_p1;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the single-outstanding
// instruction-memory handshake, parks a response in a one-entry hold buffer
// while ID is stalled, and feeds the IF/ID register.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pc_write_en,
    input  logic            if_id_enable,
    input  logic            if_id_flush,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_instr
);

    fetch_state_t    state;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] fetch_pc;
    logic            discard_q;
    logic [XLEN-1:0] hold_pc;
    logic [XLEN-1:0] hold_instr;

    logic            rsp_live;
    logic            deliver;
    logic            accept;
    logic [XLEN-1:0] d_pc;
    logic [XLEN-1:0] d_instr;

    // A response is usable only when it is not the leftover of a redirected fetch.
    assign rsp_live = (state == WAIT) && imem_rvalid && !discard_q;

    // An instruction enters IF/ID from the live response or from the hold buffer,
    // never in a redirect cycle (that cycle always bubbles IF/ID).
    assign deliver = !redirect_valid && if_id_enable && !if_id_flush &&
                     (rsp_live || (state == HOLD));

    assign d_pc    = (state == HOLD) ? hold_pc    : fetch_pc;
    assign d_instr = (state == HOLD) ? hold_instr : imem_rdata;

    // Request generation: REQ asks whenever allowed; WAIT/HOLD chain the next
    // request onto the cycle that hands an instruction to IF/ID.
    always_comb begin
        imem_req = 1'b0;
        case (state)
            REQ:        imem_req = pc_write_en && !redirect_valid;
            WAIT, HOLD: imem_req = pc_write_en && deliver;
            default:    imem_req = 1'b0;
        endcase
    end

    assign imem_addr = pc_q;
    assign accept    = imem_req && imem_ready;

    // Fetch FSM with PC, outstanding-request tag, discard flag and hold buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc_q       <= RESET_PC;
            fetch_pc   <= '0;
            discard_q  <= 1'b0;
            hold_pc    <= '0;
            hold_instr <= NOP_INSTR;
        end else if (redirect_valid) begin
            pc_q <= align_pc(redirect_pc);
            case (state)
                IDLE: state <= REQ;
                REQ:  state <= REQ;
                WAIT: begin
                    // A response in this very cycle is the one being abandoned.
                    if (imem_rvalid) begin
                        discard_q <= 1'b0;
                        state     <= REQ;
                    end else begin
                        discard_q <= 1'b1;
                    end
                end
                HOLD:    state <= REQ;
                default: state <= IDLE;
            endcase
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (accept) begin
                        fetch_pc <= pc_q;
                        pc_q     <= pc_q + PC_STEP;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (discard_q) begin
                            discard_q <= 1'b0;
                            state     <= REQ;
                        end else if (if_id_enable && !if_id_flush) begin
                            if (accept) begin
                                fetch_pc <= pc_q;
                                pc_q     <= pc_q + PC_STEP;
                                state    <= WAIT;
                            end else begin
                                state <= REQ;
                            end
                        end else if (!if_id_enable) begin
                            hold_pc    <= fetch_pc;
                            hold_instr <= imem_rdata;
                            state      <= HOLD;
                        end else begin
                            // Flush without redirect while ID advances: the word is killed.
                            state <= REQ;
                        end
                    end
                end
                HOLD: begin
                    // A flush here only bubbles IF/ID; the buffered word waits.
                    if (if_id_enable && !if_id_flush) begin
                        if (accept) begin
                            fetch_pc <= pc_q;
                            pc_q     <= pc_q + PC_STEP;
                            state    <= WAIT;
                        end else begin
                            state <= REQ;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (if_id_enable),
        .flush   (if_id_flush || redirect_valid),
        .d_valid (deliver),
        .d_pc    (d_pc),
        .d_instr (d_instr),
        .q_valid (if_id_valid),
        .q_pc    (if_id_pc),
        .q_instr (if_id_instr)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a behavioural instruction memory with
// programmable response latency, directed scenarios, and a scoreboard of the
// instructions expected to enter IF/ID.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_write_en;
    logic        if_id_enable;
    logic        if_id_flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int mem_lat;
    logic en_prev;

    logic [31:0] sb_pc[$];
    logic [31:0] sb_in[$];
    logic [31:0] mq_data[$];
    int          mq_due[$];

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_write_en    (pc_write_en),
        .if_id_enable   (if_id_enable),
        .if_id_flush    (if_id_flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_id_valid    (if_id_valid),
        .if_id_pc       (if_id_pc),
        .if_id_instr    (if_id_instr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h00C0_FFEE;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic expect_instr(input logic [31:0] pc);
        sb_pc.push_back(pc);
        sb_in.push_back(instr_of(pc));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_sb_empty(input string tag);
        chk(tag, 32'(sb_pc.size()), 32'd0);
    endtask

    always @(posedge clk) cyc++;

    // Memory: accept on req&&ready (observed at negedge), answer mem_lat cycles later.
    always @(negedge clk) begin
        if (rst_n && imem_req && imem_ready) begin
            mq_data.push_back(instr_of(imem_addr));
            mq_due.push_back(cyc + mem_lat);
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (mq_due.size() != 0 && mq_due[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mq_data.pop_front();
            void'(mq_due.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
    end

    // IF/ID monitor: a valid word after an enabled edge is a fresh delivery.
    always @(negedge clk) begin
        if (!rst_n) begin
            en_prev = 1'b0;
        end else begin
            if (if_id_valid && en_prev) begin
                if (sb_pc.size() == 0) begin
                    chk("sb_extra_delivery", 32'(sb_pc.size()), 32'd1);
                end else begin
                    chk("if_id_pc", if_id_pc, sb_pc.pop_front());
                    chk("if_id_instr", if_id_instr, sb_in.pop_front());
                end
            end
            en_prev = if_id_enable;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        pc_write_en    = 1'b1;
        if_id_enable   = 1'b1;
        if_id_flush    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_ready     = 1'b1;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        mem_lat        = 1;
        en_prev        = 1'b0;

        // Reset values, then release.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", 32'(if_id_valid), 32'd0);
        chk("rst_pc", if_id_pc, 32'h0);
        chk("rst_instr", if_id_instr, NOP);
        rst_n = 1'b1;
        #1 chk("rel_req_c0", 32'(imem_req), 32'd0);

        // A: back-to-back stream 0, 4, 8.
        expect_instr(32'h0); expect_instr(32'h4); expect_instr(32'h8);
        tick(); @(negedge clk);
        chk("A_req_c1", 32'(imem_req), 32'd1);
        chk("A_addr_c1", imem_addr, 32'h0);
        tick(); @(negedge clk);
        chk("A_addr_c2", imem_addr, 32'h4);
        tick(); @(negedge clk);
        chk("A_addr_c3", imem_addr, 32'h8);
        chk("A_ifid_c3", if_id_pc, 32'h0);
        tick(); pc_write_en = 1'b0; @(negedge clk);
        chk("A_req_off", 32'(imem_req), 32'd0);
        chk("A_ifid_c4", if_id_pc, 32'h4);
        tick(); @(negedge clk);
        chk("A_ifid_c5", if_id_pc, 32'h8);
        tick(); chk_sb_empty("A_sb_empty");

        // B: redirect to 0x100 while WAIT, old response arrives later and is dropped.
        mem_lat = 2;
        expect_instr(32'h100);
        tick(); pc_write_en = 1'b1; @(negedge clk);
        chk("B_addr_c", imem_addr, 32'hC);
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h100; @(negedge clk);
        chk("B_req_wait", 32'(imem_req), 32'd0);
        tick(); redirect_valid = 1'b0; @(negedge clk);
        chk("B_req_discard", 32'(imem_req), 32'd0);
        chk("B_valid_discard", 32'(if_id_valid), 32'd0);
        tick(); @(negedge clk);
        chk("B_req_new", 32'(imem_req), 32'd1);
        chk("B_addr_new", imem_addr, 32'h100);
        chk("B_valid_after", 32'(if_id_valid), 32'd0);
        tick(); pc_write_en = 1'b0; @(negedge clk);
        tick(); @(negedge clk);
        tick(); @(negedge clk);
        chk("B_ifid_100", if_id_pc, 32'h100);
        tick(); chk_sb_empty("B_sb_empty");

        // C: stall IF/ID three cycles while the 0x8 response arrives.
        mem_lat = 1;
        expect_instr(32'h4); expect_instr(32'h8); expect_instr(32'hC);
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h4; @(negedge clk);
        chk("C_req_redir", 32'(imem_req), 32'd0);
        tick(); redirect_valid = 1'b0; pc_write_en = 1'b1; @(negedge clk);
        chk("C_addr_4", imem_addr, 32'h4);
        tick(); @(negedge clk);
        chk("C_addr_8", imem_addr, 32'h8);
        for (int i = 0; i < 3; i++) begin
            tick(); if_id_enable = 1'b0; @(negedge clk);
            chk("C_req_stall", 32'(imem_req), 32'd0);
            chk("C_ifid_hold", if_id_pc, 32'h4);
            chk("C_valid_hold", 32'(if_id_valid), 32'd1);
        end
        tick(); if_id_enable = 1'b1; @(negedge clk);
        chk("C_req_resume", 32'(imem_req), 32'd1);
        chk("C_addr_resume", imem_addr, 32'hC);
        tick(); pc_write_en = 1'b0; @(negedge clk);
        chk("C_ifid_8", if_id_pc, 32'h8);
        tick(); @(negedge clk);
        chk("C_ifid_c", if_id_pc, 32'hC);
        tick(); chk_sb_empty("C_sb_empty");

        // D: redirect + flush with the 0x10 response; unaligned target 0x203.
        expect_instr(32'h200);
        tick(); pc_write_en = 1'b1; @(negedge clk);
        chk("D_addr_10", imem_addr, 32'h10);
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h203; if_id_flush = 1'b1; @(negedge clk);
        chk("D_req_redir", 32'(imem_req), 32'd0);
        tick(); redirect_valid = 1'b0; if_id_flush = 1'b0; @(negedge clk);
        chk("D_req_200", 32'(imem_req), 32'd1);
        chk("D_addr_200", imem_addr, 32'h200);
        chk("D_valid_bubble", 32'(if_id_valid), 32'd0);
        tick(); pc_write_en = 1'b0; @(negedge clk);
        tick(); @(negedge clk);
        chk("D_ifid_200", if_id_pc, 32'h200);
        tick(); chk_sb_empty("D_sb_empty");

        // E: PC wrap from 0xFFFF_FFFC, then async reset while WAIT.
        expect_instr(32'hFFFF_FFFC); expect_instr(32'h0);
        tick(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; @(negedge clk);
        tick(); redirect_valid = 1'b0; pc_write_en = 1'b1; @(negedge clk);
        chk("E_addr_top", imem_addr, 32'hFFFF_FFFC);
        tick(); @(negedge clk);
        chk("E_addr_wrap", imem_addr, 32'h0);
        tick(); mem_lat = 3; @(negedge clk);
        chk("E_addr_4", imem_addr, 32'h4);
        tick(); if_id_enable = 1'b0; @(negedge clk);
        tick();
        chk("E_valid_pre_rst", 32'(if_id_valid), 32'd1);
        chk_sb_empty("E_sb_empty");
        #2 rst_n = 1'b0;
        #1;
        chk("F_req_async", 32'(imem_req), 32'd0);
        chk("F_addr_async", imem_addr, 32'h0);
        chk("F_valid_async", 32'(if_id_valid), 32'd0);
        chk("F_pc_async", if_id_pc, 32'h0);
        chk("F_instr_async", if_id_instr, NOP);
        mq_data.delete(); mq_due.delete();
        if_id_enable = 1'b1;
        mem_lat = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        // Stale response from before reset lands in cycle 1 after release.
        mq_data.push_back(32'hDEAD_BEEF);
        mq_due.push_back(cyc + 1);
        expect_instr(32'h0);
        tick(); @(negedge clk);
        chk("F_req_c1", 32'(imem_req), 32'd1);
        chk("F_addr_c1", imem_addr, 32'h0);
        tick(); pc_write_en = 1'b0; @(negedge clk);
        chk("F_valid_stale", 32'(if_id_valid), 32'd0);
        tick(); @(negedge clk);
        chk("F_ifid_0", if_id_pc, 32'h0);
        chk("F_instr_0", if_id_instr, instr_of(32'h0));
        tick(); chk_sb_empty("F_sb_empty");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
